alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 8-bit add/subtract datapath with its 4-bit flag vector.
- Accepts operand/opcode requests over valid/ready handshakes and grants them round-robin.
- Registers the operands, runs one add or subtract, and returns result, flags and requester ID over a response handshake.
- Sits between the decode/execute front ends and the single adder instance, so one adder serves both.

---
 rtl/alu_arb_pkg.sv | 22 ++
 rtl/alu_addsub8.sv | 30 +++
 rtl/alu_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the two-requester add/sub arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default datapath width, flag bit positions, sequencer state encoding.
package alu_arb_pkg;

   // Default operand/result width of the shared datapath.
   localparam int DEF_W = 8;

   // Bit positions inside the 4-bit flag vector returned with each result.
   localparam int FLAG_C = 0;  // raw carry-out (1 = no borrow on subtract)
   localparam int FLAG_Z = 1;  // result is zero
   localparam int FLAG_V = 2;  // signed overflow
   localparam int FLAG_P = 3;  // odd parity of result

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_addsub8.sv
// alu_addsub8: combinational add/subtract with carry-out and signed overflow.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
// Ports: a_i, b_i operands; sub_i selects A-B; result_o, carry_o, ovf_o.
module alu_addsub8
   import alu_arb_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         sub_i,
   output logic [W-1:0] result_o,
   output logic         carry_o,
   output logic         ovf_o
);

   logic [W-1:0] b_eff;
   logic [W:0]   sum;

   // Subtract is A + ~B + 1, so carry-out reads as "no borrow".
   assign b_eff = sub_i ? ~b_i : b_i;
   assign sum   = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, sub_i};

   assign result_o = sum[W-1:0];
   assign carry_o  = sum[W];
   // Operands of equal sign producing a result of the other sign.
   assign ovf_o    = (a_i[W-1] == b_eff[W-1]) && (sum[W-1] != a_i[W-1]);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: arbitrates two requesters onto one add/sub datapath, returns result+flags+id.
// Latency: accept at edge N -> resp_valid from cycle N+2; one operation in flight, issue every 3 cycles.
// Backpressure: req*_ready only in IDLE; response held stable until resp_ready.
// Ports: req0_*/req1_* request handshakes (valid/ready, a, b, sub); resp_* response handshake
//        (valid/ready, id, result, flags[C,Z,V,P]); clk, rst_n (async active-low).
// Build option: define ALU_ARB_FIXED_PRIO_EN for strict priority (requester 0 wins ties);
//        default build uses round-robin on simultaneous requests.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter  int W    = DEF_W,
   parameter  int NREQ = 2,
   localparam int ID_W = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,

   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [W-1:0]    req0_a,
   input  logic [W-1:0]    req0_b,
   input  logic            req0_sub,

   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [W-1:0]    req1_a,
   input  logic [W-1:0]    req1_b,
   input  logic            req1_sub,

   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [ID_W-1:0] resp_id,
   output logic [W-1:0]    resp_result,
   output logic [3:0]      resp_flags
);

   state_t            state_q;
   logic [W-1:0]      a_q;
   logic [W-1:0]      b_q;
   logic              sub_q;
   logic [ID_W-1:0]   id_q;

   logic              resp_valid_q;
   logic [ID_W-1:0]   resp_id_q;
   logic [W-1:0]      resp_result_q;
   logic [3:0]        resp_flags_q;

`ifndef ALU_ARB_FIXED_PRIO_EN
   logic              rr_ptr_q;   // requester preferred on a tie
`endif

   logic              gnt0;
   logic              gnt1;
   logic [W-1:0]      sum_d;
   logic              carry_d;
   logic              ovf_d;
   logic [3:0]        flags_d;

   // Grant is only offered in IDLE; a lone requester always wins.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == IDLE) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         gnt0 = req0_valid;
         gnt1 = req1_valid && !req0_valid;
`else
         gnt0 = req0_valid && (!req1_valid || !rr_ptr_q);
         gnt1 = req1_valid && (!req0_valid ||  rr_ptr_q);
`endif
      end
   end

   // Ready is forced low while reset is held, independent of the state register.
   assign req0_ready = rst_n && gnt0;
   assign req1_ready = rst_n && gnt1;

   alu_addsub8 #(
      .W (W)
   ) u_addsub (
      .a_i      (a_q),
      .b_i      (b_q),
      .sub_i    (sub_q),
      .result_o (sum_d),
      .carry_o  (carry_d),
      .ovf_o    (ovf_d)
   );

   always_comb begin
      flags_d         = 4'b0000;
      flags_d[FLAG_C] = carry_d;
      flags_d[FLAG_Z] = ~|sum_d;
      flags_d[FLAG_V] = ovf_d;
      flags_d[FLAG_P] = ^sum_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         a_q           <= '0;
         b_q           <= '0;
         sub_q         <= 1'b0;
         id_q          <= '0;
         resp_valid_q  <= 1'b0;
         resp_id_q     <= '0;
         resp_result_q <= '0;
         resp_flags_q  <= 4'b0000;
`ifndef ALU_ARB_FIXED_PRIO_EN
         rr_ptr_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               // In IDLE ready equals grant, so a grant with valid is a handshake.
               if (gnt0 || gnt1) begin
                  a_q     <= gnt1 ? req1_a   : req0_a;
                  b_q     <= gnt1 ? req1_b   : req0_b;
                  sub_q   <= gnt1 ? req1_sub : req0_sub;
                  id_q    <= ID_W'(gnt1);
`ifndef ALU_ARB_FIXED_PRIO_EN
                  rr_ptr_q <= !gnt1;   // loser of this round is preferred next
`endif
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               resp_result_q <= sum_d;
               resp_flags_q  <= flags_d;
               resp_id_q     <= id_q;
               resp_valid_q  <= 1'b1;
               state_q       <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: begin
               resp_valid_q <= 1'b0;
               state_q      <= IDLE;
            end
         endcase
      end
   end

   assign resp_valid  = resp_valid_q;
   assign resp_id     = resp_id_q;
   assign resp_result = resp_result_q;
   assign resp_flags  = resp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter; expected responses queued at acceptance.
// Latency: n/a (testbench).
// Backpressure: bench drives resp_ready, including a multi-cycle stall.
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0_valid = 1'b0, req0_sub = 1'b0;
   logic [W-1:0] req0_a = '0, req0_b = '0;
   logic         req1_valid = 1'b0, req1_sub = 1'b0;
   logic [W-1:0] req1_a = '0, req1_b = '0;
   logic         req0_ready, req1_ready;
   logic         resp_valid;
   logic         resp_ready = 1'b1;
   logic [0:0]   resp_id;
   logic [W-1:0] resp_result;
   logic [3:0]   resp_flags;

   alu_arbiter #(.W(W), .NREQ(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_sub    (req0_sub),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_sub    (req1_sub),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_id     (resp_id),
      .resp_result (resp_result),
      .resp_flags  (resp_flags)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       id;
      logic [7:0] res;
      logic [3:0] flags;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t mk(input logic id, input logic [7:0] res, input logic [3:0] fl);
      exp_t e;
      e.id = id; e.res = res; e.flags = fl;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
   endtask

   // Monitor: pops one expectation per completed response handshake.
   exp_t got_e;
   always @(negedge clk) begin
      if (rst_n && resp_valid && resp_ready) begin
         if (exp_q.size() == 0) begin
            check("resp_unexpected", 32'd1, 32'd0);
         end else begin
            got_e = exp_q.pop_front();
            check("resp_id",     32'(resp_id),     32'(got_e.id));
            check("resp_result", 32'(resp_result), 32'(got_e.res));
            check("resp_flags",  32'(resp_flags),  32'(got_e.flags));
         end
      end
   end

   task automatic drive(input bit id, input bit v, input logic [7:0] a, input logic [7:0] b,
                        input bit sub);
      if (id) begin req1_valid = v; req1_a = a; req1_b = b; req1_sub = sub; end
      else    begin req0_valid = v; req0_a = a; req0_b = b; req0_sub = sub; end
   endtask

   // Present one request, wait (bounded) for its grant, queue the hand-computed result.
   task automatic do_op(input bit id, input logic [7:0] a, input logic [7:0] b, input bit sub,
                        input logic [7:0] eres, input logic [3:0] efl);
      int t;
      drive(id, 1'b1, a, b, sub);
      t = 0;
      @(negedge clk);
      while (!(id ? req1_ready : req0_ready) && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) check("grant_timeout", 32'd0, 32'd1);
      else exp_q.push_back(mk(id, eres, efl));
      @(posedge clk); #1;
      drive(id, 1'b0, 8'h00, 8'h00, 1'b0);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   logic rr_exp [4];
   exp_t rr_e0, rr_e1;

   initial begin
      int t;
      int prev;
      logic any;

      // ---- reset state (req0 valid must not see ready during reset) ----
      req0_valid = 1'b1;
      #22;
      check("rst_req0_ready",  32'(req0_ready),  32'd0);
      check("rst_req1_ready",  32'(req1_ready),  32'd0);
      check("rst_resp_valid",  32'(resp_valid),  32'd0);
      check("rst_resp_result", 32'(resp_result), 32'd0);
      check("rst_resp_flags",  32'(resp_flags),  32'd0);
      check("rst_resp_id",     32'(resp_id),     32'd0);
      req0_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ---- req0 0x7F+0x01 with latency probe ----
      drive(1'b0, 1'b1, 8'h7F, 8'h01, 1'b0);
      @(negedge clk);
      check("t1_req0_ready", 32'(req0_ready), 32'd1);
      exp_q.push_back(mk(1'b0, 8'h80, 4'b1100));
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      check("t1_valid_n1", 32'(resp_valid), 32'd0);
      @(negedge clk);
      check("t1_valid_n2", 32'(resp_valid), 32'd1);
      drain();

      // ---- req1: 0x05-0x05 and 0xFF+0x01 ----
      do_op(1'b1, 8'h05, 8'h05, 1'b1, 8'h00, 4'b0011);
      drain();
      do_op(1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0011);
      drain();

      // ---- both requesters valid continuously ----
`ifdef ALU_ARB_FIXED_PRIO_EN
      rr_exp[0] = 1'b0; rr_exp[1] = 1'b0; rr_exp[2] = 1'b0; rr_exp[3] = 1'b0;
`else
      rr_exp[0] = 1'b0; rr_exp[1] = 1'b1; rr_exp[2] = 1'b0; rr_exp[3] = 1'b1;
`endif
      rr_e0 = mk(1'b0, 8'h30, 4'b0000);   // 0x10 + 0x20
      rr_e1 = mk(1'b1, 8'h30, 4'b0001);   // 0x40 - 0x10, no borrow
      drive(1'b0, 1'b1, 8'h10, 8'h20, 1'b0);
      drive(1'b1, 1'b1, 8'h40, 8'h10, 1'b1);
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         t = 0;
         do begin
            @(negedge clk);
            t++;
            any = req0_ready || req1_ready;
         end while (!any && t < 20);
         if (!any) begin
            check("rr_timeout", 32'd0, 32'd1);
         end else begin
            exp_q.push_back(rr_exp[k] ? rr_e1 : rr_e0);
            if (k > 0) check("rr_issue_interval", 32'(cyc - prev), 32'd3);
            prev = cyc;
         end
      end
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      drain();

      // ---- response stall of 4 cycles ----
      resp_ready = 1'b0;
      do_op(1'b0, 8'h03, 8'h04, 1'b0, 8'h07, 4'b1000);
      drive(1'b1, 1'b1, 8'h80, 8'h01, 1'b1);   // 0x80-0x01 = 0x7F, C V P set
      @(negedge clk);
      check("stall_exec_req1_ready", 32'(req1_ready), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("stall_valid",      32'(resp_valid),  32'd1);
         check("stall_result",     32'(resp_result), 32'h07);
         check("stall_flags",      32'(resp_flags),  32'h8);
         check("stall_id",         32'(resp_id),     32'd0);
         check("stall_req0_ready", 32'(req0_ready),  32'd0);
         check("stall_req1_ready", 32'(req1_ready),  32'd0);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);       // monitor takes the stalled response here
      @(negedge clk);
      check("stall_resume_req1_ready", 32'(req1_ready), 32'd1);
      exp_q.push_back(mk(1'b1, 8'h7F, 4'b1101));
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      drain();

      // ---- reset during EXEC discards in-flight op and restores rr_ptr ----
      drive(1'b0, 1'b1, 8'h11, 8'h22, 1'b0);
      @(negedge clk);
      check("rstx_req0_ready", 32'(req0_ready), 32'd1);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rstx_resp_valid",  32'(resp_valid),  32'd0);
      check("rstx_resp_result", 32'(resp_result), 32'd0);
      check("rstx_resp_flags",  32'(resp_flags),  32'd0);
      check("rstx_resp_id",     32'(resp_id),     32'd0);
      drive(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
      drive(1'b1, 1'b1, 8'h00, 8'h01, 1'b1);   // 0x00-0x01 = 0xFF, borrow
      @(negedge clk);
      check("rstx_held_req0_ready", 32'(req0_ready), 32'd0);
      check("rstx_held_valid",      32'(resp_valid), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rstx_tie_req0_ready", 32'(req0_ready), 32'd1);
      check("rstx_tie_req1_ready", 32'(req1_ready), 32'd0);
      exp_q.push_back(mk(1'b0, 8'h02, 4'b1000));
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!req1_ready && t < 20);
      if (!req1_ready) check("rstx_req1_timeout", 32'd0, 32'd1);
      else exp_q.push_back(mk(1'b1, 8'hFF, 4'b0000));
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      drain();

      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
